// File: rtl/popcount_frame_sched.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | popcount_frame_sched: issue sequencer and per-frame accumulator    |
// | for a fixed-latency 16-input popcount core.       Revision: 1.0    |
// +--------------------------------------------------------------------+
module popcount_frame_sched #(
  parameter int LAT        = 4,
  parameter int SUMW       = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [15:0]     in_data,
  input  logic            in_last,
  input  logic            flush,
  output logic [15:0]     pc_x,
  input  logic [4:0]      pc_y,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SUMW-1:0] out_sum,
  output logic [7:0]      out_words,
  output logic [1:0]      out_flags,
  output logic            busy
);

  localparam int C_AW = $clog2(FIFO_DEPTH);
  localparam int C_CW = C_AW + 1;
  localparam int C_OW = $clog2(FIFO_DEPTH + LAT + 3);
  localparam int C_EW = SUMW + 8 + 2;
  localparam logic [SUMW-1:0] C_SUM_MAX   = '1;
  localparam logic [7:0]      C_WORDS_MAX = 8'hFF;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    EMIT  = 2'd2
  } state_t;

  state_t          r_state, w_state_nx;
  logic            r_live;
  logic            r_x_v, r_x_last;
  logic [LAT-1:0]  r_tag_v, r_tag_last;
  logic [SUMW-1:0] r_sum;
  logic [7:0]      r_words;
  logic            r_sat;
  logic [C_EW-1:0] r_mem [FIFO_DEPTH];
  logic [C_AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [C_CW-1:0] r_count;

  logic            w_accept, w_any_v, w_tail_v, w_tail_last;
  logic            w_emit, w_emit_push, w_tail_push, w_push, w_pop;
  logic [SUMW:0]   w_add;
  logic [SUMW-1:0] w_sum_nx;
  logic [7:0]      w_words_nx;
  logic            w_sat_nx;
  logic [C_EW-1:0] w_push_data, w_head;
  logic [C_OW-1:0] w_open;

  assign w_tail_v    = r_tag_v[LAT-1];
  assign w_tail_last = r_tag_last[LAT-1];
  assign w_any_v     = r_x_v | (|r_tag_v);
  assign busy        = w_any_v | (r_state != RUN);

  // Every frame that will eventually need a FIFO slot holds a credit from
  // the moment its closing word issues (or a flush starts) until popped.
  always_comb begin
    w_open = C_OW'(r_count) + C_OW'(r_x_last) + C_OW'(r_state != RUN);
    for (int i = 0; i < LAT; i++) begin
      w_open = w_open + C_OW'(r_tag_last[i]);
    end
  end

  assign in_ready = r_live & (r_state == RUN) & ~flush & (w_open < C_OW'(FIFO_DEPTH));
  assign w_accept = in_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_live   <= 1'b0;
      r_x_v    <= 1'b0;
      r_x_last <= 1'b0;
      pc_x     <= '0;
    end else begin
      r_live   <= 1'b1;
      r_x_v    <= w_accept;
      r_x_last <= w_accept & in_last;
      pc_x     <= w_accept ? in_data : 16'h0000;
    end
  end

  // Tag pipeline runs alongside the core so the tail lines up with pc_y.
  generate
    if (LAT == 1) begin : g_tag_lat1
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_tag_v    <= '0;
          r_tag_last <= '0;
        end else begin
          r_tag_v    <= r_x_v;
          r_tag_last <= r_x_last;
        end
      end
    end else begin : g_tag_latn
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_tag_v    <= '0;
          r_tag_last <= '0;
        end else begin
          r_tag_v    <= {r_tag_v[LAT-2:0], r_x_v};
          r_tag_last <= {r_tag_last[LAT-2:0], r_x_last};
        end
      end
    end
  endgenerate

  assign w_add      = {1'b0, r_sum} + (SUMW+1)'(pc_y);
  assign w_sum_nx   = w_add[SUMW] ? C_SUM_MAX : w_add[SUMW-1:0];
  assign w_sat_nx   = r_sat | w_add[SUMW];
  assign w_words_nx = (r_words == C_WORDS_MAX) ? r_words : r_words + 8'd1;

  always_comb begin
    w_state_nx  = r_state;
    w_emit      = 1'b0;
    w_emit_push = 1'b0;
    case (r_state)
      RUN:     if (flush) w_state_nx = DRAIN;
      DRAIN:   if (!w_any_v) w_state_nx = EMIT;
      EMIT: begin
        w_emit      = 1'b1;
        w_emit_push = (r_words != 8'd0);
        w_state_nx  = RUN;
      end
      default: w_state_nx = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= RUN;
    else     r_state <= w_state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum   <= '0;
      r_words <= '0;
      r_sat   <= 1'b0;
    end else if (w_tail_v && w_tail_last) begin
      r_sum   <= '0;
      r_words <= '0;
      r_sat   <= 1'b0;
    end else if (w_tail_v) begin
      r_sum   <= w_sum_nx;
      r_words <= w_words_nx;
      r_sat   <= w_sat_nx;
    end else if (w_emit) begin
      r_sum   <= '0;
      r_words <= '0;
      r_sat   <= 1'b0;
    end
  end

  assign w_tail_push = w_tail_v & w_tail_last;
  assign w_push      = w_tail_push | w_emit_push;
  assign w_push_data = w_tail_push ? {w_sum_nx, w_words_nx, w_sat_nx, 1'b0}
                                   : {r_sum, r_words, r_sat, 1'b1};
  assign w_pop       = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + C_AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + C_AW'(1);
      r_count <= r_count + C_CW'(w_push) - C_CW'(w_pop);
    end
  end

  assign w_head    = r_mem[r_rd_ptr];
  assign out_valid = (r_count != '0);
  assign out_sum   = out_valid ? w_head[C_EW-1 -: SUMW] : '0;
  assign out_words = out_valid ? w_head[9:2] : '0;
  assign out_flags = out_valid ? w_head[1:0] : '0;

endmodule
`default_nettype wire

// File: tb/tb_popcount_frame_sched.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_popcount_frame_sched: directed bench with a frame-level model   |
// | and a behavioural popcount core.                  Revision: 1.0    |
// +--------------------------------------------------------------------+
module tb_popcount_frame_sched;

  localparam int LAT   = 4;
  localparam int SUMW  = 5;
  localparam int DEPTH = 4;
  localparam int SMAX  = (1 << SUMW) - 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_last = 1'b0;
  logic            flush = 1'b0;
  logic            out_ready = 1'b0;
  logic [15:0]     in_data = 16'h0000;
  logic            in_ready;
  logic [15:0]     pc_x;
  logic [4:0]      pc_y;
  logic            out_valid;
  logic [SUMW-1:0] out_sum;
  logic [7:0]      out_words;
  logic [1:0]      out_flags;
  logic            busy;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  typedef struct {
    int sum;
    int words;
    int flags;
    int due;
  } ent_t;

  ent_t        q[$];
  int          m_sum = 0;
  int          m_words = 0;
  int          m_sat = 0;
  logic [15:0] exp_pcx = 16'h0000;
  logic [4:0]  core_pipe [LAT];

  always #5 clk = ~clk;

  popcount_frame_sched #(.LAT(LAT), .SUMW(SUMW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .flush(flush), .pc_x(pc_x),
    .pc_y(pc_y), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_words(out_words), .out_flags(out_flags),
    .busy(busy)
  );

  // External core: no reset, so stale counts survive a scheduler reset.
  always @(posedge clk) begin
    core_pipe[0] <= 5'($countones(pc_x));
    for (int i = 1; i < LAT; i++) core_pipe[i] <= core_pipe[i-1];
  end
  assign pc_y = core_pipe[LAT-1];

  task automatic chk(input string nm, input longint got, input longint exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
  endtask

  // Frame model: words close frames in acceptance order; results due LAT+1
  // cycles after the closing word is taken.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      q.delete();
      m_sum = 0; m_words = 0; m_sat = 0;
      exp_pcx = 16'h0000;
    end else begin
      if (out_valid && out_ready && q.size() != 0) q.delete(0);
      exp_pcx = 16'h0000;
      if (in_valid && in_ready) begin
        exp_pcx = in_data;
        m_sum += $countones(in_data);
        if (m_sum > SMAX) begin m_sum = SMAX; m_sat = 1; end
        if (m_words < 255) m_words++;
        if (in_last) begin
          q.push_back('{m_sum, m_words, m_sat * 2, cyc + LAT + 1});
          m_sum = 0; m_words = 0; m_sat = 0;
        end
      end
      if (flush) begin
        if (m_words != 0) q.push_back('{m_sum, m_words, m_sat * 2 + 1, 0});
        m_sum = 0; m_words = 0; m_sat = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_pc_x", pc_x, 0);
      chk("rst_out_sum", out_sum, 0);
      chk("rst_out_words", out_words, 0);
      chk("rst_out_flags", out_flags, 0);
    end else begin
      chk("pc_x", pc_x, exp_pcx);
      if (out_valid) begin
        chk("out_has_model", q.size() != 0, 1);
        if (q.size() != 0) begin
          chk("out_sum", out_sum, q[0].sum);
          chk("out_words", out_words, q[0].words);
          chk("out_flags", out_flags, q[0].flags);
        end
      end
      if (q.size() != 0 && q[0].due != 0 && cyc >= q[0].due)
        chk("out_due", out_valid, 1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d, input logic l);
    int n = 0;
    in_valid = 1'b1; in_data = d; in_last = l;
    while (!in_ready && n < 200) begin tick(); n++; end
    chk("send_ready", in_ready, 1);
    tick();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_out(input int es, input int ew, input int ef, input string nm, output int lat);
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 40) begin @(negedge clk); n++; end
    lat = n;
    chk({nm, "_valid"}, out_valid, 1);
    chk({nm, "_sum"}, out_sum, es);
    chk({nm, "_words"}, out_words, ew);
    chk({nm, "_flags"}, out_flags, ef);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int n;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready", in_ready, 0);
    tick();
    rst = 1'b0;
    tick(); tick();
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1);
    chk("idle_busy", busy, 0);
    chk("idle_out_valid", out_valid, 0);
    tick();

    // Three-word frame, consumer always ready.
    out_ready = 1'b1;
    send(16'hFFFF, 1'b0);
    send(16'h0001, 1'b0);
    send(16'h00F0, 1'b1);
    wait_out(21, 3, 0, "t1", lat);
    chk("t1_latency", lat, 5);
    tick();

    // Partial frame closed by flush; word offered with flush is refused.
    send(16'h0003, 1'b0);
    flush = 1'b1; in_valid = 1'b1; in_data = 16'hFFFF; in_last = 1'b1;
    @(negedge clk);
    chk("t2_ready_at_flush", in_ready, 0);
    tick();
    flush = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    chk("t2_ready_drain", in_ready, 0);
    n = 0;
    while (!in_ready && n < 30) begin @(negedge clk); n++; end
    chk("t2_ready_back", in_ready, 1);
    chk("t2_valid", out_valid, 1);
    chk("t2_sum", out_sum, 2);
    chk("t2_words", out_words, 1);
    chk("t2_flags", out_flags, 1);
    tick();

    // Flush with an empty frame: DRAIN, EMIT, then RUN, no result.
    flush = 1'b1;
    @(negedge clk);
    tick();
    flush = 1'b0;
    @(negedge clk); chk("t5_busy_drain", busy, 1);
    @(negedge clk); chk("t5_busy_emit", busy, 1);
    @(negedge clk); chk("t5_busy_run", busy, 0);
    chk("t5_ready_run", in_ready, 1);
    repeat (4) @(negedge clk);
    chk("t5_no_result", out_valid, 0);
    tick();

    // Credit limit: four 1-word frames fill every slot.
    out_ready = 1'b0;
    send(16'h0001, 1'b1);
    send(16'h0003, 1'b1);
    send(16'h0007, 1'b1);
    send(16'h000F, 1'b1);
    in_valid = 1'b1; in_data = 16'h001F; in_last = 1'b1;
    @(negedge clk);
    chk("t3_full_ready", in_ready, 0);
    repeat (8) tick();
    @(negedge clk);
    chk("t3_still_full", in_ready, 0);
    chk("t3_head_sum", out_sum, 1);
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    chk("t3_pop_cycle_ready", in_ready, 0);
    tick();
    out_ready = 1'b0;
    @(negedge clk);
    chk("t3_ready_after_pop", in_ready, 1);
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    chk("t3_refull", in_ready, 0);
    tick();
    out_ready = 1'b1;
    wait_out(2, 1, 0, "t3a", lat); tick();
    wait_out(3, 1, 0, "t3b", lat); tick();
    wait_out(4, 1, 0, "t3c", lat); tick();
    wait_out(5, 1, 0, "t3d", lat); tick();

    // Sum saturation at 2^SUMW-1.
    send(16'hFFFF, 1'b0);
    send(16'hFFFF, 1'b0);
    send(16'hFFFF, 1'b1);
    wait_out(31, 3, 2, "t4", lat);
    tick();

    // Word-count saturation: 256 zero words.
    for (int i = 0; i < 256; i++) send(16'h0000, i == 255);
    wait_out(0, 255, 0, "t6", lat);
    tick();

    // Reset with one queued result and two words in flight.
    out_ready = 1'b0;
    send(16'h0007, 1'b1);
    wait_out(3, 1, 0, "t7q", lat);
    tick();
    send(16'h00FF, 1'b0);
    send(16'h0FFF, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("t7_rst_valid", out_valid, 0);
    chk("t7_rst_busy", busy, 0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("t7_no_stale", out_valid, 0);
    end
    tick();
    send(16'h0001, 1'b1);
    wait_out(1, 1, 0, "t7_fresh", lat);
    tick();

    repeat (3) tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
